// File: rtl/video_line_fifo.sv
// video_line_fifo: parametrised line FIFO with occupancy flags, sticky errors, flush and recirculate
module video_line_fifo #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = 240
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     recirc,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] push_data;
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count_n;
  logic rd_acc, rc_act, wr_acc, push;
  always_comb begin
    rd_acc    = rd_en && !empty;
    rc_act    = recirc && rd_acc;
    wr_acc    = wr_en && !rc_act && (!full || rd_acc);
    push      = wr_acc || rc_act;
    push_data = rc_act ? mem[rd_ptr[AW-1:0]] : wr_data;
    wr_ptr_n  = wr_ptr + (AW+1)'(push);
    rd_ptr_n  = rd_ptr + (AW+1)'(rd_acc);
    count_n   = count + (AW+1)'(push) - (AW+1)'(rd_acc);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      empty       <= wr_ptr_n == rd_ptr_n;
      full        <= (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
      almost_full <= count_n >= (AW+1)'(AF_LEVEL);
      rd_valid    <= rd_acc;
      if (rd_acc) rd_data <= mem[rd_ptr[AW-1:0]];
      overflow    <= overflow || (wr_en && !wr_acc);
      underflow   <= underflow || (rd_en && empty);
    end
endmodule

// File: doc/video_line_fifo.md
Name: video_line_fifo

Overview:
Parametrised synchronous FIFO for buffering pixel/line data in the video memory path. It replaces the fixed 1-bit, 256-entry line buffer with configurable data width and depth. It adds exact full/empty and occupancy reporting, an almost-full threshold, sticky error flags and a synchronous flush. It also adds a recirculate mode that replays a stored line (pop head, re-push at tail) for vertical pixel doubling.

Parameters:
WIDTH, 1, data word width in bits (>=1)
DEPTH, 256, number of entries; power of two, >=2
AF_LEVEL, 240, almost_full asserts when count >= AF_LEVEL (1..DEPTH)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush: pointers, count and error flags to reset values
wr_en  input  1  write request
wr_data  input  WIDTH  write data
rd_en  input  1  read request
recirc  input  1  when high, an accepted read also re-pushes the popped word at the tail
rd_data  output  WIDTH  registered read data
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (rst high, async): wr/rd pointers 0, count 0, empty=1, full=0, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Memory array is not reset. Reset mid-transfer discards all contents.
- clr (sync, priority over all requests): same state as reset except rd_data holds its value. rd_valid=0 that cycle.
- Pointers are clog2(DEPTH)+1 bits. Wrap is natural modulo 2*DEPTH. full/empty are derived from pointer equality and the MSB. All DEPTH entries are usable.
- Flags full, empty, almost_full and count are registered and reflect state after the previous edge.
- Read accept: rd_en && !empty. The head word goes to rd_data and rd_valid=1 in the cycle after the accepting edge, so latency is 1. No fall-through. rd_data holds its value when no read is accepted.
- Write accept: wr_en && !recirc_active && (!full || read_accept). Full plus a simultaneous accepted read lets the write in; count is unchanged.
- Empty with simultaneous rd_en and wr_en: write accepted, read rejected (no bypass), underflow set.
- recirc_active = recirc && read_accept. The popped word is written at the tail the same edge and count is unchanged. Any wr_en in that cycle is ignored and sets overflow.
- recirc && rd_en while empty: nothing happens; underflow set.
- Rejected write (wr_en, not accepted): overflow set. Rejected read (rd_en && empty): underflow set. Both stay set until rst or clr.
- count update: +1 on write-only, -1 on read-only, unchanged on both or recirculate. Never exceeds DEPTH and never goes below 0.
- Memory: DEPTH x WIDTH register/RAM array. A write and a read to the same index in one cycle (possible only when full with a simultaneous read) returns the old word.

Test Plan:
- Fill/drain, WIDTH=8, DEPTH=16: write 0x00..0x0F. full=1 and count=16 after the 16th edge. A 17th write sets overflow=1 with count still 16. Then read 16: rd_data=0x00..0x0F in order, each 1 cycle after rd_en. empty=1 and count=0 at the end.
- Simultaneous ops: at full, rd_en+wr_en with 0xAA → rd_data=0x00, count stays 16, 0xAA read last. At empty, rd_en+wr_en with 0x55 → underflow=1, count=1, next read returns 0x55.
- Recirculate: load 4 words 0x1..0x4, then 8 reads with recirc=1 → rd_data 1,2,3,4,1,2,3,4 and count stays 4. A wr_en during recirc is ignored and sets overflow=1.
- Almost-full/wrap, AF_LEVEL=12: almost_full rises on count 11→12 and falls on 12→11. Stream 100 words through with occupancy held near 8; data stays intact across several pointer wraps.
- clr and async reset: with 5 words held, pulse clr → count=0, empty=1, flags cleared, rd_data unchanged. Assert rst between clock edges mid-write → all outputs go to reset values immediately; no write is accepted while rst is high.
